// File: rtl/punc_control.sv
// punc_control -- control FSM for the PUnC LC3 processor.
//
// Sequences FETCH / DECODE / EXEC (/ EXEC2 for LDI and STI) from the
// instruction register value returned by the datapath, and drives every
// datapath control input. Outputs are Moore-style: a function of the
// current state and ir only.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ir[15:0]            instruction register from the datapath
//   mem_wr_en           memory write strobe
//   mem_r_addr_sel[2:0] read address: 0 pc, 1 pc_adder, 2 indirect, 3 mem data, 4 alu
//   state2_STI          write address comes from the indirect latch
//   STR                 STR addressing; write data is RF_r_data_1
//   RF_*                register file write/read controls
//   RF_w_data_sel[1:0]  write data: 0 alu, 1 pc, 2 mem, 3 pc_adder
//   ir_ld               load instruction register
//   JMP_RET_JSRR        PC load source is the alu
//   pc_ld/pc_clr/pc_up  program counter controls
//   add_const           alu B operand is the sign-extended constant
//   alu_sel[1:0]        0 PASS, 1 ADD, 2 AND, 3 NOT
//   cc_en               update condition codes
//   n, z, p             branch condition mask (nonzero only in BR EXEC)
//   const_n[10:0]       ir[10:0]
//   SEXT_Select[3:0]    1000 imm5, 0100 off6, 0010 off9, 0001 off11
//   halted              high while in HALT

module punc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    output logic        mem_wr_en,
    output logic [2:0]  mem_r_addr_sel,
    output logic        state2_STI,
    output logic        STR,
    output logic [2:0]  RF_wr_addr,
    output logic        RF_wr_en,
    output logic [2:0]  RF_r_addr_0,
    output logic [2:0]  RF_r_addr_1,
    output logic [1:0]  RF_w_data_sel,
    output logic        ir_ld,
    output logic        JMP_RET_JSRR,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_up,
    output logic        add_const,
    output logic [1:0]  alu_sel,
    output logic        cc_en,
    output logic        n,
    output logic        z,
    output logic        p,
    output logic [10:0] const_n,
    output logic [3:0]  SEXT_Select,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_INIT, S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011,
        OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
        OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011,
        OP_JMP = 4'b1100, OP_RES = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0, ALU_ADD = 2'd1, ALU_AND = 2'd2, ALU_NOT = 2'd3
    } alu_t;

    localparam logic [3:0] SEXT_IMM5  = 4'b1000;
    localparam logic [3:0] SEXT_OFF6  = 4'b0100;
    localparam logic [3:0] SEXT_OFF9  = 4'b0010;
    localparam logic [3:0] SEXT_OFF11 = 4'b0001;

    state_t  r_state;
    state_t  w_next;
    opcode_t w_op;
    logic [2:0] w_dr;
    logic [2:0] w_base;
    logic [2:0] w_sr2;

    assign w_op    = opcode_t'(ir[15:12]);
    assign w_dr    = ir[11:9];
    assign w_base  = ir[8:6];
    assign w_sr2   = ir[2:0];
    assign const_n = ir[10:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        mem_wr_en      = 1'b0;
        mem_r_addr_sel = 3'd0;
        state2_STI     = 1'b0;
        STR            = 1'b0;
        RF_wr_addr     = '0;
        RF_wr_en       = 1'b0;
        RF_r_addr_0    = '0;
        RF_r_addr_1    = '0;
        RF_w_data_sel  = 2'd0;
        ir_ld          = 1'b0;
        JMP_RET_JSRR   = 1'b0;
        pc_ld          = 1'b0;
        pc_clr         = 1'b0;
        pc_up          = 1'b0;
        add_const      = 1'b0;
        alu_sel        = ALU_PASS;
        cc_en          = 1'b0;
        n              = 1'b0;
        z              = 1'b0;
        p              = 1'b0;
        SEXT_Select    = '0;
        halted         = 1'b0;

        case (r_state)
            S_INIT: begin
                pc_clr = 1'b1;
                w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_r_addr_sel = 3'd0;
                ir_ld          = 1'b1;
                pc_up          = 1'b1;
                w_next         = S_DECODE;
            end
            S_DECODE: begin
                w_next = (w_op == OP_TRAP) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_op)
                    OP_ADD, OP_AND: begin
                        RF_r_addr_0   = w_base;
                        RF_r_addr_1   = w_sr2;
                        add_const     = ir[5];
                        SEXT_Select   = SEXT_IMM5;
                        alu_sel       = (w_op == OP_ADD) ? ALU_ADD : ALU_AND;
                        RF_wr_en      = 1'b1;
                        RF_wr_addr    = w_dr;
                        RF_w_data_sel = 2'd0;
                        cc_en         = 1'b1;
                    end
                    OP_NOT: begin
                        RF_r_addr_0   = w_base;
                        alu_sel       = ALU_NOT;
                        RF_wr_en      = 1'b1;
                        RF_wr_addr    = w_dr;
                        RF_w_data_sel = 2'd0;
                        cc_en         = 1'b1;
                    end
                    OP_BR: begin
                        {n, z, p}    = ir[11:9];
                        SEXT_Select  = SEXT_OFF9;
                        JMP_RET_JSRR = 1'b0;
                    end
                    OP_LD: begin
                        mem_r_addr_sel = 3'd1;
                        SEXT_Select    = SEXT_OFF9;
                        RF_wr_en       = 1'b1;
                        RF_wr_addr     = w_dr;
                        RF_w_data_sel  = 2'd2;
                    end
                    OP_LDR: begin
                        RF_r_addr_0    = w_base;
                        add_const      = 1'b1;
                        SEXT_Select    = SEXT_OFF6;
                        alu_sel        = ALU_ADD;
                        mem_r_addr_sel = 3'd4;
                        RF_wr_en       = 1'b1;
                        RF_wr_addr     = w_dr;
                        RF_w_data_sel  = 2'd2;
                    end
                    OP_LEA: begin
                        SEXT_Select   = SEXT_OFF9;
                        RF_wr_en      = 1'b1;
                        RF_wr_addr    = w_dr;
                        RF_w_data_sel = 2'd3;
                    end
                    OP_ST: begin
                        RF_r_addr_0 = w_dr;
                        alu_sel     = ALU_PASS;
                        SEXT_Select = SEXT_OFF9;
                        mem_wr_en   = 1'b1;
                    end
                    OP_STR: begin
                        STR         = 1'b1;
                        RF_r_addr_0 = w_base;
                        RF_r_addr_1 = w_dr;
                        add_const   = 1'b1;
                        SEXT_Select = SEXT_OFF6;
                        alu_sel     = ALU_ADD;
                        mem_wr_en   = 1'b1;
                    end
                    OP_LDI, OP_STI: begin
                        // Datapath's indirect latch captures the pointer at this edge.
                        mem_r_addr_sel = 3'd1;
                        SEXT_Select    = SEXT_OFF9;
                        w_next         = S_EXEC2;
                    end
                    OP_JSR: begin
                        RF_wr_en      = 1'b1;
                        RF_wr_addr    = 3'd7;
                        RF_w_data_sel = 2'd1;
                        pc_ld         = 1'b1;
                        if (ir[11]) begin
                            SEXT_Select  = SEXT_OFF11;
                            JMP_RET_JSRR = 1'b0;
                        end else begin
                            RF_r_addr_0  = w_base;
                            alu_sel      = ALU_PASS;
                            JMP_RET_JSRR = 1'b1;
                        end
                    end
                    OP_JMP: begin
                        RF_r_addr_0  = w_base;
                        alu_sel      = ALU_PASS;
                        JMP_RET_JSRR = 1'b1;
                        pc_ld        = 1'b1;
                    end
                    default: ; // RTI, reserved, TRAP (unreachable here): NOP
                endcase
            end
            S_EXEC2: begin
                w_next = S_FETCH;
                // ir holds LDI (1010) or STI (1011); bit 12 separates them.
                if (ir[12]) begin
                    state2_STI  = 1'b1;
                    RF_r_addr_0 = w_dr;
                    alu_sel     = ALU_PASS;
                    mem_wr_en   = 1'b1;
                end else begin
                    mem_r_addr_sel = 3'd2;
                    RF_wr_en       = 1'b1;
                    RF_wr_addr     = w_dr;
                    RF_w_data_sel  = 2'd2;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: w_next = S_INIT;
        endcase

        // Kill write strobes combinationally so no partial write lands
        // on the edge following a mid-instruction reset.
        if (rst) begin
            mem_wr_en = 1'b0;
            RF_wr_en  = 1'b0;
        end
    end

endmodule

// File: tb/tb_punc_control.sv
// tb_punc_control -- table-driven bench for punc_control: each vector
// walks reset -> INIT -> FETCH -> DECODE -> EXEC (-> EXEC2) and compares
// the full control bundle against hand-computed values.

module tb_punc_control;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic        mem_wr_en;
    logic [2:0]  mem_r_addr_sel;
    logic        state2_STI;
    logic        STR;
    logic [2:0]  RF_wr_addr;
    logic        RF_wr_en;
    logic [2:0]  RF_r_addr_0;
    logic [2:0]  RF_r_addr_1;
    logic [1:0]  RF_w_data_sel;
    logic        ir_ld;
    logic        JMP_RET_JSRR;
    logic        pc_ld;
    logic        pc_clr;
    logic        pc_up;
    logic        add_const;
    logic [1:0]  alu_sel;
    logic        cc_en;
    logic        n;
    logic        z;
    logic        p;
    logic [10:0] const_n;
    logic [3:0]  SEXT_Select;
    logic        halted;

    punc_control dut (
        .clk(clk), .rst(rst), .ir(ir),
        .mem_wr_en(mem_wr_en), .mem_r_addr_sel(mem_r_addr_sel),
        .state2_STI(state2_STI), .STR(STR),
        .RF_wr_addr(RF_wr_addr), .RF_wr_en(RF_wr_en),
        .RF_r_addr_0(RF_r_addr_0), .RF_r_addr_1(RF_r_addr_1),
        .RF_w_data_sel(RF_w_data_sel), .ir_ld(ir_ld),
        .JMP_RET_JSRR(JMP_RET_JSRR), .pc_ld(pc_ld), .pc_clr(pc_clr),
        .pc_up(pc_up), .add_const(add_const), .alu_sel(alu_sel),
        .cc_en(cc_en), .n(n), .z(z), .p(p), .const_n(const_n),
        .SEXT_Select(SEXT_Select), .halted(halted)
    );

    typedef struct packed {
        logic       mem_wr_en;
        logic [2:0] mem_r_addr_sel;
        logic       state2_STI;
        logic       STR;
        logic [2:0] RF_wr_addr;
        logic       RF_wr_en;
        logic [2:0] RF_r_addr_0;
        logic [2:0] RF_r_addr_1;
        logic [1:0] RF_w_data_sel;
        logic       ir_ld;
        logic       JMP_RET_JSRR;
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_up;
        logic       add_const;
        logic [1:0] alu_sel;
        logic       cc_en;
        logic [2:0] nzp;
        logic [3:0] sext;
        logic       halted;
    } ctl_t;

    typedef struct {
        string       name;
        logic [15:0] ir;
        ctl_t        ex;
        logic        two;
        ctl_t        ex2;
        logic        halt;
    } vec_t;

    ctl_t act;
    assign act = {mem_wr_en, mem_r_addr_sel, state2_STI, STR, RF_wr_addr, RF_wr_en,
                  RF_r_addr_0, RF_r_addr_1, RF_w_data_sel, ir_ld, JMP_RET_JSRR,
                  pc_ld, pc_clr, pc_up, add_const, alu_sel, cc_en, n, z, p,
                  SEXT_Select, halted};

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];
    ctl_t C_INIT, C_FETCH, C_DEC, C_HALT;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input ctl_t a, input ctl_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, a, e);
        end
    endtask

    task automatic chk_bits(input string name, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, a, e);
        end
    endtask

    task automatic add(input string name, input logic [15:0] i, input ctl_t e,
                       input logic two, input ctl_t e2, input logic halt);
        vec_t v;
        v.name = name; v.ir = i; v.ex = e; v.two = two; v.ex2 = e2; v.halt = halt;
        vecs.push_back(v);
    endtask

    task automatic run(input vec_t v);
        logic [10:0] cn;
        cn = v.ir[10:0];
        @(negedge clk);
        rst = 1'b1;
        ir  = v.ir;
        #1 rst = 1'b0;
        #1 chk({v.name, "_init"}, act, C_INIT);
        @(posedge clk); #2 chk({v.name, "_fetch"}, act, C_FETCH);
        @(posedge clk); #2 chk({v.name, "_decode"}, act, C_DEC);
        if (v.halt) begin
            @(posedge clk); #2 chk({v.name, "_halt"}, act, C_HALT);
            ir = 16'h1283;
            @(posedge clk); #2 chk({v.name, "_halt_sticky1"}, act, C_HALT);
            @(posedge clk); #2 chk({v.name, "_halt_sticky2"}, act, C_HALT);
        end else begin
            @(posedge clk); #2 chk({v.name, "_exec"}, act, v.ex);
            chk_bits({v.name, "_const_n"}, {5'd0, const_n}, {5'd0, cn});
            if (v.two) begin
                @(posedge clk); #2 chk({v.name, "_exec2"}, act, v.ex2);
            end
            @(posedge clk); #2 chk({v.name, "_refetch"}, act, C_FETCH);
        end
    endtask

    initial begin
        ctl_t c;
        ctl_t c2;
        rst = 1'b1;
        ir  = 16'h0000;

        C_INIT = '0;  C_INIT.pc_clr = 1'b1;
        C_FETCH = '0; C_FETCH.ir_ld = 1'b1; C_FETCH.pc_up = 1'b1;
        C_DEC = '0;
        C_HALT = '0;  C_HALT.halted = 1'b1;

        // ADD R1,R2,R3
        c = '0; c.RF_r_addr_0 = 3'd2; c.RF_r_addr_1 = 3'd3; c.sext = 4'b1000;
        c.alu_sel = 2'd1; c.RF_wr_en = 1'b1; c.RF_wr_addr = 3'd1; c.cc_en = 1'b1;
        add("add_reg", 16'h1283, c, 1'b0, '0, 1'b0);
        // ADD R1,R0,#5
        c = '0; c.RF_r_addr_0 = 3'd0; c.RF_r_addr_1 = 3'd5; c.add_const = 1'b1;
        c.sext = 4'b1000; c.alu_sel = 2'd1; c.RF_wr_en = 1'b1; c.RF_wr_addr = 3'd1;
        c.cc_en = 1'b1;
        add("add_imm", 16'h1225, c, 1'b0, '0, 1'b0);
        // AND R5,R2,R7
        c = '0; c.RF_r_addr_0 = 3'd2; c.RF_r_addr_1 = 3'd7; c.sext = 4'b1000;
        c.alu_sel = 2'd2; c.RF_wr_en = 1'b1; c.RF_wr_addr = 3'd5; c.cc_en = 1'b1;
        add("and_reg", 16'h5A9F, c, 1'b0, '0, 1'b0);
        // NOT R5,R1
        c = '0; c.RF_r_addr_0 = 3'd1; c.alu_sel = 2'd3; c.RF_wr_en = 1'b1;
        c.RF_wr_addr = 3'd5; c.cc_en = 1'b1;
        add("not", 16'h9A7F, c, 1'b0, '0, 1'b0);
        // BRz +2
        c = '0; c.nzp = 3'b010; c.sext = 4'b0010;
        add("brz", 16'h0402, c, 1'b0, '0, 1'b0);
        // BRn +1
        c = '0; c.nzp = 3'b100; c.sext = 4'b0010;
        add("brn", 16'h0801, c, 1'b0, '0, 1'b0);
        // LD R6,#5
        c = '0; c.mem_r_addr_sel = 3'd1; c.sext = 4'b0010; c.RF_wr_en = 1'b1;
        c.RF_wr_addr = 3'd6; c.RF_w_data_sel = 2'd2;
        add("ld", 16'h2C05, c, 1'b0, '0, 1'b0);
        // LDR R3,R4,#-1 (no cc update)
        c = '0; c.RF_r_addr_0 = 3'd4; c.add_const = 1'b1; c.sext = 4'b0100;
        c.alu_sel = 2'd1; c.mem_r_addr_sel = 3'd4; c.RF_wr_en = 1'b1;
        c.RF_wr_addr = 3'd3; c.RF_w_data_sel = 2'd2;
        add("ldr", 16'h673F, c, 1'b0, '0, 1'b0);
        // LEA R4
        c = '0; c.sext = 4'b0010; c.RF_wr_en = 1'b1; c.RF_wr_addr = 3'd4;
        c.RF_w_data_sel = 2'd3;
        add("lea", 16'hE80A, c, 1'b0, '0, 1'b0);
        // ST R2
        c = '0; c.RF_r_addr_0 = 3'd2; c.sext = 4'b0010; c.mem_wr_en = 1'b1;
        add("st", 16'h3403, c, 1'b0, '0, 1'b0);
        // STR R5,R2,#1
        c = '0; c.STR = 1'b1; c.RF_r_addr_0 = 3'd2; c.RF_r_addr_1 = 3'd5;
        c.add_const = 1'b1; c.sext = 4'b0100; c.alu_sel = 2'd1; c.mem_wr_en = 1'b1;
        add("str", 16'h7A81, c, 1'b0, '0, 1'b0);
        // LDI R3 (4-cycle)
        c = '0; c.mem_r_addr_sel = 3'd1; c.sext = 4'b0010;
        c2 = '0; c2.mem_r_addr_sel = 3'd2; c2.RF_wr_en = 1'b1; c2.RF_wr_addr = 3'd3;
        c2.RF_w_data_sel = 2'd2;
        add("ldi", 16'hA60F, c, 1'b1, c2, 1'b0);
        // STI R2 (write only in EXEC2)
        c = '0; c.mem_r_addr_sel = 3'd1; c.sext = 4'b0010;
        c2 = '0; c2.state2_STI = 1'b1; c2.RF_r_addr_0 = 3'd2; c2.mem_wr_en = 1'b1;
        add("sti", 16'hB430, c, 1'b1, c2, 1'b0);
        // JSR +4
        c = '0; c.RF_wr_en = 1'b1; c.RF_wr_addr = 3'd7; c.RF_w_data_sel = 2'd1;
        c.pc_ld = 1'b1; c.sext = 4'b0001;
        add("jsr", 16'h4804, c, 1'b0, '0, 1'b0);
        // JSRR R7
        c = '0; c.RF_wr_en = 1'b1; c.RF_wr_addr = 3'd7; c.RF_w_data_sel = 2'd1;
        c.pc_ld = 1'b1; c.RF_r_addr_0 = 3'd7; c.JMP_RET_JSRR = 1'b1;
        add("jsrr", 16'h41C0, c, 1'b0, '0, 1'b0);
        // RET
        c = '0; c.RF_r_addr_0 = 3'd7; c.JMP_RET_JSRR = 1'b1; c.pc_ld = 1'b1;
        add("ret", 16'hC1C0, c, 1'b0, '0, 1'b0);
        // RTI and reserved: NOP
        add("rti", 16'h8000, '0, 1'b0, '0, 1'b0);
        add("reserved", 16'hD123, '0, 1'b0, '0, 1'b0);
        // TRAP halts after DECODE
        add("trap", 16'hF025, '0, 1'b0, '0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) run(vecs[i]);

        // Reset asserted mid-ST EXEC: write strobe drops at once, FSM in INIT.
        @(negedge clk);
        rst = 1'b1; ir = 16'h3403;
        #1 rst = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #2 chk_bits("st_pre_reset_wr", {15'd0, mem_wr_en}, 16'd1);
        rst = 1'b1;
        #1 chk_bits("st_reset_wr", {14'd0, mem_wr_en, RF_wr_en}, 16'd0);
        @(negedge clk);
        #1 chk_bits("st_reset_hold_wr", {14'd0, mem_wr_en, RF_wr_en}, 16'd0);
        rst = 1'b0;
        #1 chk("st_reset_init", act, C_INIT);
        @(posedge clk); #2 chk("st_reset_fetch", act, C_FETCH);

        // Reset asserted mid-LDI EXEC2: register write strobe drops at once.
        @(negedge clk);
        rst = 1'b1; ir = 16'hA60F;
        #1 rst = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); @(posedge clk);
        #2 chk_bits("ldi_pre_reset_wr", {15'd0, RF_wr_en}, 16'd1);
        rst = 1'b1;
        #1 chk_bits("ldi_reset_wr", {14'd0, mem_wr_en, RF_wr_en}, 16'd0);
        rst = 1'b0;
        #1 chk("ldi_reset_init", act, C_INIT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
